// File: rtl/edge_filter_pkg.sv
// Shared defaults and helpers for the edge filter bank.
// Holds the default parameter values and the filter-counter width function.
package edge_filter_pkg;

  localparam int   DEF_CHANNELS    = 4;
  localparam int   DEF_SYNC_STAGES = 2;
  localparam int   DEF_FILT_LEN    = 3;
  localparam logic DEF_RESET_LEVEL = 1'b0;
  localparam int   DEF_CNT_W       = 8;

  // The counter must be able to hold FILT_LEN-1.
  // Sizing it to clog2(FILT_LEN+1) keeps at least one bit when FILT_LEN=1.
  function automatic int filt_cnt_w(input int filt_len);
    return (filt_len < 1) ? 1 : $clog2(filt_len + 1);
  endfunction

endpackage

// File: rtl/edge_filter_chan.sv
// One channel: synchroniser, glitch filter, polarity-aware edge detector,
// sticky pending flag and optional saturating edge counter (EDGE_FILTER_BANK_COUNT_EN).
module edge_filter_chan
  import edge_filter_pkg::*;
#(
  parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int   FILT_LEN    = DEF_FILT_LEN,
  parameter logic RESET_LEVEL = DEF_RESET_LEVEL,
  parameter int   CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             signal,
  input  logic             cpol,
  input  logic             clear,
  output logic             level,
  output logic             positive_edge,
  output logic             negative_edge,
`ifdef EDGE_FILTER_BANK_COUNT_EN
  output logic [CNT_W-1:0] edge_count,
`endif
  output logic             pending
);

  localparam int             FCW       = filt_cnt_w(FILT_LEN);
  localparam logic [FCW-1:0] FILT_LAST = FCW'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sync_out;
  logic [FCW-1:0]         filt_cnt_reg, filt_cnt_next;
  logic                   level_reg, level_next;
  logic                   toggle;
  logic                   pos_reg, pos_next;
  logic                   neg_reg, neg_next;
  logic                   pending_reg, pending_next;

  assign sync_out = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], signal};
    end
  end

  // Level only moves once the synchronised input has disagreed for FILT_LEN edges.
  always_comb begin
    filt_cnt_next = '0;
    toggle        = 1'b0;
    if (sync_out != level_reg) begin
      if (filt_cnt_reg == FILT_LAST) begin
        toggle = 1'b1;
      end else begin
        filt_cnt_next = filt_cnt_reg + FCW'(1);
      end
    end
    level_next = level_reg ^ toggle;
  end

  // cpol is applied to the new level on the toggle edge, so only later pulses see a change.
  always_comb begin
    pos_next     = toggle & (level_next ^ cpol);
    neg_next     = toggle & ~(level_next ^ cpol);
    pending_next = pos_reg | neg_reg | (pending_reg & ~clear);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_cnt_reg <= '0;
      level_reg    <= RESET_LEVEL;
      pos_reg      <= 1'b0;
      neg_reg      <= 1'b0;
      pending_reg  <= 1'b0;
    end else begin
      filt_cnt_reg <= filt_cnt_next;
      level_reg    <= level_next;
      pos_reg      <= pos_next;
      neg_reg      <= neg_next;
      pending_reg  <= pending_next;
    end
  end

  assign level         = level_reg;
  assign positive_edge = pos_reg;
  assign negative_edge = neg_reg;
  assign pending       = pending_reg;

`ifdef EDGE_FILTER_BANK_COUNT_EN
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  // A clear coinciding with a pulse restarts the count at one.
  always_comb begin
    cnt_next = cnt_reg;
    if (clear) begin
      cnt_next = CNT_W'(pos_reg);
    end else if (pos_reg && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign edge_count = cnt_reg;
`endif

endmodule

// File: rtl/edge_filter_bank.sv
// Bank of independent filtered edge detectors, one edge_filter_chan per channel.
// Define EDGE_FILTER_BANK_COUNT_EN to add the per-channel edge_count outputs.
module edge_filter_bank
  import edge_filter_pkg::*;
#(
  parameter int   CHANNELS    = DEF_CHANNELS,
  parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int   FILT_LEN    = DEF_FILT_LEN,
  parameter logic RESET_LEVEL = DEF_RESET_LEVEL,
  parameter int   CNT_W       = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       signal,
  input  logic [CHANNELS-1:0]       cpol,
  input  logic [CHANNELS-1:0]       clear,
  output logic [CHANNELS-1:0]       level,
  output logic [CHANNELS-1:0]       positive_edge,
  output logic [CHANNELS-1:0]       negative_edge,
`ifdef EDGE_FILTER_BANK_COUNT_EN
  output logic [CHANNELS*CNT_W-1:0] edge_count,
`endif
  output logic [CHANNELS-1:0]       pending
);

  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("edge_filter_bank: SYNC_STAGES must be >= 2");
    end
    if (FILT_LEN < 1) begin : g_bad_filt
      $error("edge_filter_bank: FILT_LEN must be >= 1");
    end
    if (CHANNELS < 1) begin : g_bad_chan
      $error("edge_filter_bank: CHANNELS must be >= 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt
      $error("edge_filter_bank: CNT_W must be >= 1");
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      edge_filter_chan #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN),
        .RESET_LEVEL (RESET_LEVEL),
        .CNT_W       (CNT_W)
      ) u_chan (
        .clk           (clk),
        .rst_n         (rst_n),
        .signal        (signal[gi]),
        .cpol          (cpol[gi]),
        .clear         (clear[gi]),
        .level         (level[gi]),
        .positive_edge (positive_edge[gi]),
        .negative_edge (negative_edge[gi]),
`ifdef EDGE_FILTER_BANK_COUNT_EN
        .edge_count    (edge_count[gi*CNT_W +: CNT_W]),
`endif
        .pending       (pending[gi])
      );
    end
  endgenerate

endmodule

// File: doc/edge_filter_bank.md
EDGE_FILTER_BANK -- requirements
Module: edge_filter_bank

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of independent input channels (>=1).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, flip-flops in each input synchroniser (>=2).
REQ-003 SHALL have parameter FILT_LEN, default 3, consecutive equal samples needed to accept a level change (>=1; 1 = no filtering).
REQ-004 SHALL have parameter RESET_LEVEL, default 1'b0, reset value of synchroniser and filtered level.
REQ-005 SHALL have parameter CNT_W, default 8, width of each edge counter.
REQ-006 SHALL have port clk  input  1  the single clock; all state on its rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port signal  input  CHANNELS  raw asynchronous input lines.
REQ-009 SHALL have port cpol  input  CHANNELS  per-channel polarity select, runtime.
REQ-010 SHALL have port clear  input  CHANNELS  per-channel clear of pending flag and counter.
REQ-011 SHALL have port level  output  CHANNELS  filtered, synchronised level.
REQ-012 SHALL have port positive_edge  output  CHANNELS  one-cycle leading-edge pulse.
REQ-013 SHALL have port negative_edge  output  CHANNELS  one-cycle trailing-edge pulse.
REQ-014 SHALL have port pending  output  CHANNELS  sticky "any edge seen" flag.
REQ-015 SHALL have port edge_count  output  CHANNELS*CNT_W  per-channel positive_edge counters, channel i at bits [i*CNT_W +: CNT_W] (present only per REQ-030).

Function
REQ-016 Each channel SHALL pass signal through a SYNC_STAGES-deep flip-flop chain; only the last stage is used downstream.
REQ-017 Per channel a counter of width clog2(FILT_LEN+1) SHALL increment while synchroniser output differs from level and return to 0 when they are equal.
REQ-018 level SHALL toggle, and the counter SHALL return to 0, on the edge where the counter would reach FILT_LEN; shorter pulses SHALL leave level unchanged.
REQ-019 Latency: a change stable across the sampling edge (edge 1) SHALL appear on level and on the edge pulse after edge SYNC_STAGES+FILT_LEN.
REQ-020 positive_edge and negative_edge SHALL be registered, high for exactly one cycle on the cycle level toggles, never both in one cycle.
REQ-021 cpol=0: 0->1 of level gives positive_edge, 1->0 gives negative_edge; cpol=1: mapping swapped.
REQ-022 cpol SHALL be sampled on the edge that registers the pulse; a cpol change affects only later pulses, never level or filter state.
REQ-023 pending[i] SHALL set on either edge pulse of channel i and stay set until clear[i]; simultaneous set and clear SHALL leave it set.
REQ-024 edge_count[i] SHALL increment on each positive_edge[i], saturate at all-ones, and go to 0 on clear[i]; simultaneous clear and increment SHALL yield 1.
REQ-025 Channels SHALL be fully independent; simultaneous events on several channels SHALL each be handled in the same cycle.

Reset
REQ-026 rst_n low SHALL asynchronously set synchroniser stages and level to RESET_LEVEL, filter counters, edge pulses, pending and edge_count to 0.
REQ-027 Reset asserted mid-filtering SHALL discard the partial count; no pulse SHALL be generated by reset assertion or release.
REQ-028 After release, first transition from RESET_LEVEL SHALL be reported as a normal edge.

Configuration
REQ-029 Macro EDGE_FILTER_BANK_COUNT_EN SHALL control the edge counters.
REQ-030 Defined: edge_count port and counters present per REQ-024; undefined: port and counter logic absent, all other behaviour identical.

Structure
REQ-031 Package edge_filter_pkg SHALL hold default parameter constants and the filter-counter width function.
REQ-032 One sub-module edge_filter_chan (synchroniser, filter, detector, pending, counter for one channel) SHALL be instantiated CHANNELS times by generate loop.
REQ-033 Elaboration SHALL fail if SYNC_STAGES<2, FILT_LEN<1, CHANNELS<1 or CNT_W<1.

Verification
REQ-034 Defaults, cpol=0, signal[0] 0->1 held: positive_edge[0] high one cycle after edge 5, level[0]=1, pending[0]=1, edge_count[0]=1.
REQ-035 FILT_LEN=3, 2-cycle glitch on signal[1]: no pulse, level[1] unchanged, pending[1]=0.
REQ-036 cpol[2]=1, signal[2] 1->0 then 0->1: positive_edge on the fall, negative_edge on the rise.
REQ-037 CNT_W=2, 5 rising edges on channel 3: edge_count[3]=3; clear with 6th edge pulse same cycle: count=1, pending stays 1.
REQ-038 rst_n low 2 cycles into filtering a change: all outputs 0 at once, no pulse after release until a full SYNC_STAGES+FILT_LEN qualification.
REQ-039 Macro undefined build: REQ-034..036 pass unchanged, edge_count absent.
